// File: rtl/tanh_backward_unit_pkg.sv
// Shared constants and fixed-point type for the tanh backward-gradient unit.
// Default format is Q3.4: 1.0 is encoded as 16, results clip to [-128, 127].
package tanh_backward_unit_pkg;

  localparam int W    = 8;
  localparam int FRAC = 4;
  localparam int ONE  = 32'sd1 <<< FRAC;
  localparam int SMIN = -(32'sd1 <<< (W - 1));
  localparam int SMAX = (32'sd1 <<< (W - 1)) - 32'sd1;

  typedef logic signed [W-1:0] fixed_t;

endpackage : tanh_backward_unit_pkg

// File: rtl/tanh_backward_mulrs.sv
// Combinational signed multiply, round-half-up by FRAC bits, and clip to W bits.
// The unclipped rounded value is also exposed for callers that post-process it.
module tanh_backward_mulrs
  import tanh_backward_unit_pkg::*;
#(
  parameter int W    = tanh_backward_unit_pkg::W,
  parameter int FRAC = tanh_backward_unit_pkg::FRAC
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  output logic signed [2*W:0] rounded,
  output logic signed [W-1:0] result,
  output logic                sat
);

  localparam logic signed [2*W:0] HALF = {{(2*W){1'b0}}, 1'b1} <<< (FRAC - 1);
  localparam logic signed [2*W:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  logic signed [2*W-1:0] prod_s;
  logic signed [2*W:0]   biased_s;

  // Sign-extend both operands so the low 2W bits hold the exact signed product.
  assign prod_s   = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
  assign biased_s = {prod_s[2*W-1], prod_s} + HALF;
  assign rounded  = biased_s >>> FRAC;

  // Clip the rounded value into the signed W-bit range and flag any clipping.
  always_comb begin
    result = rounded[W-1:0];
    sat    = 1'b0;
    if (rounded > MAXV) begin
      result = MAXV[W-1:0];
      sat    = 1'b1;
    end else if (rounded < MINV) begin
      result = MINV[W-1:0];
      sat    = 1'b1;
    end else begin
      result = rounded[W-1:0];
      sat    = 1'b0;
    end
  end

endmodule : tanh_backward_mulrs

// File: rtl/tanh_backward_unit.sv
// Two-stage pipelined tanh backward pass: d = g * (1 - a^2) in signed fixed point,
// with valid/ready handshakes on both sides and a saturating clip counter.
module tanh_backward_unit
  import tanh_backward_unit_pkg::*;
#(
  parameter int W    = tanh_backward_unit_pkg::W,
  parameter int FRAC = tanh_backward_unit_pkg::FRAC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a_value,
  input  logic signed [W-1:0] g_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] d_value,
  input  logic                sat_clr,
  output logic [7:0]          sat_count
);

  localparam logic signed [2*W+1:0] ONE_X   = {{(2*W+1){1'b0}}, 1'b1} <<< FRAC;
  localparam logic signed [2*W+1:0] S_MAX_X = {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W+1:0] S_MIN_X = {{(W+3){1'b1}}, {(W-1){1'b0}}};

  logic signed [2*W:0]   sq_round_s;
  logic signed [W-1:0]   sq_clip_val_s;
  logic                  sq_clip_s;
  logic signed [2*W+1:0] s_wide_s;
  logic signed [W-1:0]   s_s;
  logic signed [2*W:0]   q_round_s;
  logic signed [W-1:0]   d_s;
  logic                  d_clip_s;
  logic                  adv2_s;
  logic                  in_ready_s;
  logic                  load2_s;
  logic                  rnd_unused_s;

  logic                  v1_r;
  logic                  v2_r;
  logic signed [W-1:0]   s_r;
  logic signed [W-1:0]   g_r;
  logic signed [W-1:0]   d_r;
  logic [7:0]            sat_cnt_r;

  // Stage 1 squares a; the unclipped rounded square feeds 1 - a^2 directly.
  tanh_backward_mulrs #(.W(W), .FRAC(FRAC)) u_square (
    .x       (a_value),
    .y       (a_value),
    .rounded (sq_round_s),
    .result  (sq_clip_val_s),
    .sat     (sq_clip_s)
  );

  assign s_wide_s = ONE_X - {sq_round_s[2*W], sq_round_s};

  // Clip 1 - a^2 into the signed W-bit range before it is registered.
  always_comb begin
    s_s = s_wide_s[W-1:0];
    if (s_wide_s > S_MAX_X) begin
      s_s = S_MAX_X[W-1:0];
    end else if (s_wide_s < S_MIN_X) begin
      s_s = S_MIN_X[W-1:0];
    end else begin
      s_s = s_wide_s[W-1:0];
    end
  end

  // Stage 2 scales the carried gradient by the registered slope.
  tanh_backward_mulrs #(.W(W), .FRAC(FRAC)) u_scale (
    .x       (g_r),
    .y       (s_r),
    .rounded (q_round_s),
    .result  (d_s),
    .sat     (d_clip_s)
  );

  assign rnd_unused_s = ^{sq_clip_val_s, sq_clip_s, q_round_s};

  assign adv2_s     = !v2_r | out_ready;
  assign in_ready_s = !v1_r | adv2_s;
  assign load2_s    = adv2_s & v1_r;

  // Stage 1: slope and gradient are captured together on an input transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_r <= 1'b0;
      s_r  <= {W{1'b0}};
      g_r  <= {W{1'b0}};
    end else if (in_ready_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        s_r <= s_s;
        g_r <= g_value;
      end
    end
  end

  // Stage 2: result register only changes when a stage-1 pair moves in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v2_r <= 1'b0;
      d_r  <= {W{1'b0}};
    end else if (adv2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        d_r <= d_s;
      end
    end
  end

  // Saturation counter: clear wins over a same-cycle increment, holds at 255.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_cnt_r <= 8'd0;
    end else if (sat_clr) begin
      sat_cnt_r <= 8'd0;
    end else if (load2_s && d_clip_s && (sat_cnt_r != 8'hFF)) begin
      sat_cnt_r <= sat_cnt_r + 8'd1;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = v2_r;
  assign d_value   = d_r;
  assign sat_count = sat_cnt_r;

endmodule : tanh_backward_unit

// File: tb/tb_tanh_backward_unit.sv
// Scoreboard bench for tanh_backward_unit: expected results come from an integer
// model of d = g*(1-a^2) and are checked by a monitor as outputs transfer.
module tb_tanh_backward_unit;
  import tanh_backward_unit_pkg::*;

  localparam int HALF = 1 << (FRAC - 1);

  typedef struct {
    int d;
    bit sat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  fixed_t            a_value = '0;
  fixed_t            g_value = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [7:0] d_value;
  logic              sat_clr = 1'b0;
  logic [7:0]        sat_count;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  exp_t exp_q[$];
  bit   rand_phase = 1'b0;

  tanh_backward_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_value   (a_value),
    .g_value   (g_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_value   (d_value),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  function automatic int clamp(int x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  // Reference: round-half-up fixed-point products with clipping, in plain integers.
  function automatic exp_t model(int a, int g);
    exp_t e;
    int sq, s, q;
    sq = (a * a + HALF) >>> FRAC;
    s  = clamp(ONE - sq);
    q  = (g * s + HALF) >>> FRAC;
    e.d   = clamp(q);
    e.sat = (q != e.d);
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got d=%0d, expected no output (t=%0t)", d_value, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("d_value", int'(d_value), e.d);
        n_out++;
      end
    end
  end

  task automatic drive(int a, int g);
    a_value  = fixed_t'(a);
    g_value  = fixed_t'(g);
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(int'(a_value), int'(g_value)));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept_in_time", int'(done), 1);
  endtask

  task automatic send(int a, int g);
    drive(a, g);
    wait_accept();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, hold, nsat, a, g;
    exp_t e;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_d_value", int'(d_value), 0);
    check("reset_sat_count", int'(sat_count), 0);
    rst = 1'b1;
    check("in_ready_after_reset", int'(in_ready), 1);
    out_ready = 1'b1;

    // a=0, g=16: result appears two cycles after acceptance
    send(0, 16);
    @(posedge clk);
    #1;
    check("latency_out_valid", int'(out_valid), 1);
    check("latency_d_value", int'(d_value), 16);
    check("latency_sat_count", int'(sat_count), 0);
    wait_drain();

    // Back-to-back stream
    base = n_out;
    send(16, 16);
    send(8, 16);
    send(-8, 32);
    wait_drain();
    check("stream_count", n_out - base, 3);

    // Saturation counting, hold at 255, clear priority
    send(-128, 127);
    wait_drain();
    check("sat_count_one", int'(sat_count), 1);
    for (int i = 0; i < 299; i++) send(-128, 127);
    wait_drain();
    check("sat_count_hold", int'(sat_count), 255);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check("sat_clr_idle", int'(sat_count), 0);
    send(-128, 127);
    wait_drain();
    check("sat_count_after_clr", int'(sat_count), 1);
    send(-128, 127);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check("sat_clr_wins", int'(sat_count), 0);
    wait_drain();

    // Backpressure: two accepts fill the pipe, third waits, output holds
    out_ready = 1'b0;
    base = n_out;
    send(8, 16);
    send(4, 16);
    check("bp_in_ready_low", int'(in_ready), 0);
    hold = int'(d_value);
    drive(-8, 32);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_held", int'(in_ready), 0);
      check("bp_d_stable", int'(d_value), hold);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    wait_drain();
    check("bp_count", n_out - base, 3);

    // Reset with both stages full discards everything in flight
    out_ready = 1'b0;
    send(0, 16);
    send(0, 32);
    check("full_out_valid", int'(out_valid), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_d_value", int'(d_value), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    base = n_out;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_stale", n_out - base, 0);

    // Randomized traffic with random backpressure
    nsat = 0;
    rand_phase = 1'b1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          case ($urandom_range(0, 7))
            0: a = -128;
            1: a = 127;
            default: a = int'($urandom_range(0, 255)) - 128;
          endcase
          g = int'($urandom_range(0, 255)) - 128;
          e = model(a, g);
          if (e.sat) nsat++;
          send(a, g);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_phase = 1'b0;
      end
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    check("random_sat_count", int'(sat_count), (nsat > 255) ? 255 : nsat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tanh_backward_unit

// File: doc/tanh_backward_unit.md
TANH_BACKWARD_UNIT -- requirements
Module: tanh_backward_unit

Interface
REQ-001 SHALL have parameter W, default 8, data width in bits of every signed fixed-point port.
REQ-002 SHALL have parameter FRAC, default 4, number of fraction bits; the default format is Q3.4 and 1.0 is encoded as 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand pair is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the unit accepts the pair this cycle.
REQ-007 SHALL have port a_value, input, signed W: the forward activation output a = tanh(z).
REQ-008 SHALL have port g_value, input, signed W: the upstream gradient dL/da.
REQ-009 SHALL have port out_valid, output, 1 bit: d_value holds a result.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes d_value this cycle.
REQ-011 SHALL have port d_value, output, signed W: the gradient dL/dz = g*(1-a^2).
REQ-012 SHALL have port sat_clr, input, 1 bit: clears sat_count.
REQ-013 SHALL have port sat_count, output, 8 bits: the number of saturated results.

Function
REQ-014 A transfer SHALL occur when valid and ready are both 1, on each side independently.
REQ-015 The unit SHALL be a 2-stage pipeline with valid bits v1 and v2, and out_valid SHALL equal v2.
REQ-016 Stage 2 SHALL advance when adv2 = !v2 | out_ready, and in_ready SHALL equal !v1 | adv2 (purely combinational from state and out_ready).
REQ-017 Latency SHALL be 2 cycles from the input transfer to out_valid=1, with throughput of 1 result per cycle under no backpressure.
REQ-018 Stage 1 SHALL compute the full-precision product p = a*a (2W bits), round it as sq = (p + 2^(FRAC-1)) >>> FRAC, and compute s = 2^FRAC - sq, saturated to the signed-W range [-128,127]; s SHALL be registered.
REQ-019 Stage 2 SHALL compute q = g*s (2W bits) and d = (q + 2^(FRAC-1)) >>> FRAC with an arithmetic shift, saturated to [-128,127]; d SHALL be registered into d_value.
REQ-020 The operand g SHALL be carried alongside s in stage 1.
REQ-021 A result SHALL count as saturated when stage-2 saturation clipped d.
REQ-022 While out_valid=1 and out_ready=0, d_value and stage 1 contents SHALL hold stable, and in_ready SHALL drop once v1=1.
REQ-023 When v2=0 and stage 1 is empty, d_value SHALL retain its last value.
REQ-024 sat_count SHALL increment by 1 on each stage-2 load of a saturated result.
REQ-025 sat_count SHALL hold at 255 (no wrap).
REQ-026 When sat_clr=1, sat_count SHALL become 0, including when an increment occurs in the same cycle (clear wins).
REQ-027 Simultaneous input and output transfers with both stages full SHALL lose and duplicate no data.

Reset
REQ-028 While rst=0 at a clock edge, v1, v2, out_valid, d_value, the stage-1 registers and sat_count SHALL all be set to 0.
REQ-029 A reset mid-operation SHALL discard all in-flight pairs.
REQ-030 in_ready SHALL read 1 in the first cycle after reset deasserts.

Structure
REQ-031 A shared package SHALL hold W, FRAC, ONE = 2^FRAC, SMIN = -128, SMAX = 127, and the signed fixed-point type.
REQ-032 One sub-module, tanh_backward_mulrs, SHALL perform the combinational signed multiply-round-saturate and report a saturated flag.
REQ-033 tanh_backward_mulrs SHALL be instantiated twice: once for a*a and once for g*s.

Verification
REQ-034 a=0, g=16 -> d_value=16 exactly 2 cycles after acceptance; sat_count=0.
REQ-035 Stream a=16, g=16; a=8, g=16; a=-8, g=32 with out_ready=1 -> d_value = 0, 12, 24 on consecutive cycles.
REQ-036 a=-128, g=127 -> s saturates to -128, d_value=-128, sat_count=1; 300 such pairs -> sat_count=255; sat_clr pulsed in an increment cycle -> 0.
REQ-037 out_ready=0 for 5 cycles with 3 pairs offered -> in_ready=0 after 2 accepts, d_value stable; then release -> all results appear in order with no gaps or duplicates.
REQ-038 rst=0 asserted with both stages full -> next cycle out_valid=0, d_value=0, in_ready=1; no stale result ever emerges.
